display_frame_scheduler: RTL and testbench
==========================================

# display_frame_scheduler

- Owns the 8x8 RGB image shown on the LED matrix.
- Two writers (game logic and animation) update a back buffer column by column through a round-robin arbiter.
- A commit request copies the back buffer into the front buffer only at a display frame boundary, so no frame is ever shown half-updated.
- Front buffer outputs drive the display wrapper's `image_red`/`image_green`/`image_blue` inputs; `col_num` from the display driver marks frame boundaries.

## Interface
Parameters:
- `NUM_WR`, 2, number of writers (fixed at 2; the arbiter assumes 2).
- `CNT_W`, 8, width of `commit_count`.

Ports:
- `clk` in 1: 100 MHz system clock.
- `rst` in 1: synchronous, active-high reset.
- `wr_valid` in [1:0]: write request per writer.
- `wr_ready` out [1:0]: grant per writer; a write transfers when `wr_valid[i] & wr_ready[i]`.
- `wr_col` in [1:0][2:0]: target column (0 = left) per writer.
- `wr_red`, `wr_green`, `wr_blue` in [1:0][7:0]: column data per writer; MSB = top row.
- `clear_req` in 1: zero the whole back buffer.
- `commit_req` in 1: publish the back buffer at the next frame boundary.
- `commit_busy` out 1: high while a commit waits for the boundary.
- `commit_done` out 1: one-cycle pulse after the front buffer updates.
- `commit_count` out CNT_W: number of completed commits, wraps.
- `col_num` in 3: current display column from the display driver.
- `image_red`, `image_green`, `image_blue` out [0:7][7:0]: front buffer, index 0 = left column.

## Operation
States:
- IDLE: accepts writes, clear and commit.
- PENDING: waits for a frame boundary; `commit_busy`=1, `wr_ready`=0.

Frame boundary:
- `boundary` = (`col_prev`==7 && `col_num`==0).
- `col_prev` is `col_num` registered every cycle.

Arbitration (IDLE only, at most one write per cycle):
- If only one `wr_valid` is high, that writer is granted.
- If both are high, the writer named by `prio` is granted.
- `prio` flips to the other writer after each accepted write.
- `wr_ready` is combinational from `wr_valid`, `prio`, state and `clear_req`.

Writes:
- An accepted write replaces all three colour planes of `back[wr_col]` at the next edge.

Clear:
- `clear_req` in IDLE zeroes all of `back` at the next edge.
- While `clear_req` is high, both `wr_ready` are 0.
- `clear_req` in PENDING is ignored.

Commit:
- `commit_req` in IDLE moves the block to PENDING at the next edge.
- A write or clear accepted in that same cycle is included in the commit.
- In PENDING, when `boundary`=1: front <= back, go to IDLE, `commit_done`=1 in the next cycle, `commit_count`+1.
- Back keeps its contents after the copy, so incremental edits carry over.
- `commit_req` while PENDING is absorbed (no queuing).

Reset:
- front=0, back=0, state=IDLE, `prio`=writer 0, `col_prev`=0, `commit_done`=0, `commit_count`=0, `commit_busy`=0.
- `rst` has priority over every other input in that cycle.
- Reset mid-commit abandons the commit: no `commit_done`, front is zeroed.

## Timing
- Write to back: 1 cycle. Back is never visible on the outputs directly.
- Commit latency: between 2 cycles and one full display frame plus 2 cycles after `commit_req`.
- The front buffer changes only on the edge where `boundary`=1, so every displayed frame is consistent.
- `commit_done` is registered: high exactly 1 cycle, on the cycle after front changes.
- A boundary in IDLE has no effect.
- A boundary in the same cycle as `commit_req` (IDLE) does not commit; the next boundary does.
- Outputs `image_*` are registers with no combinational path from inputs.

## Structure
- Package `nim_display_pkg` holds:
  - `typedef logic [0:7][7:0] col_image_t`
  - `localparam NUM_COLS = 8`
  - `localparam LAST_COL = 3'd7`
  - the state enum `sched_state_t {S_IDLE, S_PENDING}`
- One sub-module: `rr_arbiter2`, a two-requester round-robin arbiter with `req[1:0]`, `en`, `gnt[1:0]`, and an internal `prio` flop updated on accept.
- Target size: about 200 lines of RTL.

## Test plan
1. Reset, then writer 0 writes col 3 = R 8'hF0 G 8'h0F B 8'hAA; commit; sweep `col_num` 0..7,0 -> outputs stay 0 until the boundary edge, then `image_red[3]`=F0, `image_green[3]`=0F, `image_blue[3]`=AA; `commit_done` pulses once; `commit_count`=1.
2. Both writers valid for 4 cycles on cols 0/1 -> grants alternate 0,1,0,1; back holds the last data of each writer.
3. `commit_req` then writes held valid -> `wr_ready`=0 until commit_done; a second `commit_req` while PENDING -> only one `commit_done`, `commit_count`+1.
4. `clear_req` and `wr_valid[0]` in the same cycle -> `wr_ready`=0; after commit all outputs are 0.
5. `rst` asserted while PENDING -> `commit_busy`=0, outputs 0, no `commit_done` at the next boundary.
6. `commit_req` in the same cycle as `col_num` 7->0 -> no update; the update happens at the following 7->0 transition.

Source files
------------

// File: rtl/nim_display_pkg.sv
// Shared types and constants for the LED-matrix frame scheduler.
package nim_display_pkg;

    // One colour plane: 8 columns (index 0 = left), each 8 rows with MSB = top row.
    typedef logic [0:7][7:0] col_image_t;

    localparam int unsigned NUM_COLS = 8;
    localparam logic [2:0]  LAST_COL = 3'd7;

    typedef enum logic [0:0] {
        S_IDLE,
        S_PENDING
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; priority moves to the loser after each grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // prio_q names the requester that wins a tie (0 = requester 0)
    logic prio_q;
    logic prio_d;

    // Grant decode: a single requester always wins, a tie goes to prio_q
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // After a grant, the other requester wins the next tie
    always_comb begin
        prio_d = prio_q;
        if (|gnt) begin
            prio_d = gnt[0];
        end
    end

    // Priority register
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/display_frame_scheduler.sv
// Double-buffered 8x8 RGB image: writers edit the back buffer, and a commit copies it
// to the displayed front buffer only on a display frame boundary (column 7 -> 0).
module display_frame_scheduler
    import nim_display_pkg::*;
#(
    parameter int unsigned NUM_WR = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_WR-1:0]            wr_valid,
    output logic [NUM_WR-1:0]            wr_ready,
    input  logic [NUM_WR-1:0][2:0]       wr_col,
    input  logic [NUM_WR-1:0][7:0]       wr_red,
    input  logic [NUM_WR-1:0][7:0]       wr_green,
    input  logic [NUM_WR-1:0][7:0]       wr_blue,
    input  logic                         clear_req,
    input  logic                         commit_req,
    output logic                         commit_busy,
    output logic                         commit_done,
    output logic [CNT_W-1:0]             commit_count,
    input  logic [2:0]                   col_num,
    output col_image_t                   image_red,
    output col_image_t                   image_green,
    output col_image_t                   image_blue
);

    sched_state_t state_q, state_d;

    logic [2:0]   col_prev_q;
    logic         boundary;

    logic         arb_en;
    logic         clear_accept;
    logic         copy_front;
    logic [1:0]   gnt;
    logic         wr_sel;

    col_image_t   back_red_q, back_green_q, back_blue_q;
    col_image_t   back_red_d, back_green_d, back_blue_d;
    col_image_t   front_red_q, front_green_q, front_blue_q;
    col_image_t   front_red_d, front_green_d, front_blue_d;

    logic         done_q;
    logic [CNT_W-1:0] count_q, count_d;

    assign boundary = (col_prev_q == LAST_COL) && (col_num == 3'd0);

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (wr_valid),
        .en  (arb_en),
        .gnt (gnt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: IDLE waits for a commit request, PENDING waits for the frame boundary
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (commit_req) begin
                    state_d = S_PENDING;
                end
            end
            S_PENDING: begin
                if (boundary) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: writes and clear only in IDLE, clear masks both writers
    always_comb begin
        commit_busy  = (state_q == S_PENDING);
        arb_en       = (state_q == S_IDLE) && !clear_req;
        clear_accept = (state_q == S_IDLE) && clear_req;
        copy_front   = (state_q == S_PENDING) && boundary;
    end

    assign wr_ready = gnt;
    assign wr_sel   = gnt[1];

    // Back buffer next state: clear wins over a write; a write replaces a whole column
    always_comb begin
        back_red_d   = back_red_q;
        back_green_d = back_green_q;
        back_blue_d  = back_blue_q;
        if (clear_accept) begin
            back_red_d   = '0;
            back_green_d = '0;
            back_blue_d  = '0;
        end else if (|gnt) begin
            back_red_d[wr_col[wr_sel]]   = wr_red[wr_sel];
            back_green_d[wr_col[wr_sel]] = wr_green[wr_sel];
            back_blue_d[wr_col[wr_sel]]  = wr_blue[wr_sel];
        end
    end

    // Front buffer and commit counter change only on the boundary edge of a pending commit
    always_comb begin
        front_red_d   = front_red_q;
        front_green_d = front_green_q;
        front_blue_d  = front_blue_q;
        count_d       = count_q;
        if (copy_front) begin
            front_red_d   = back_red_q;
            front_green_d = back_green_q;
            front_blue_d  = back_blue_q;
            count_d       = count_q + CNT_W'(1);
        end
    end

    // Datapath registers; reset also abandons any pending commit
    always_ff @(posedge clk) begin
        if (rst) begin
            col_prev_q    <= 3'd0;
            back_red_q    <= '0;
            back_green_q  <= '0;
            back_blue_q   <= '0;
            front_red_q   <= '0;
            front_green_q <= '0;
            front_blue_q  <= '0;
            done_q        <= 1'b0;
            count_q       <= '0;
        end else begin
            col_prev_q    <= col_num;
            back_red_q    <= back_red_d;
            back_green_q  <= back_green_d;
            back_blue_q   <= back_blue_d;
            front_red_q   <= front_red_d;
            front_green_q <= front_green_d;
            front_blue_q  <= front_blue_d;
            done_q        <= copy_front;
            count_q       <= count_d;
        end
    end

    assign commit_done  = done_q;
    assign commit_count = count_q;
    assign image_red    = front_red_q;
    assign image_green  = front_green_q;
    assign image_blue   = front_blue_q;

endmodule

// File: tb/tb_display_frame_scheduler.sv
// Scoreboard bench: each accepted commit pushes the expected frame, each commit_done pops it.
module tb_display_frame_scheduler;
    import nim_display_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       wr_valid;
    logic [1:0]       wr_ready;
    logic [1:0][2:0]  wr_col;
    logic [1:0][7:0]  wr_red, wr_green, wr_blue;
    logic             clear_req, commit_req;
    logic             commit_busy, commit_done;
    logic [7:0]       commit_count;
    logic [2:0]       col_num;
    col_image_t       image_red, image_green, image_blue;

    typedef struct {
        col_image_t r;
        col_image_t g;
        col_image_t b;
        logic [7:0] cnt;
    } frame_t;

    frame_t     sb[$];
    frame_t     mf;
    col_image_t m_red, m_green, m_blue;
    logic       m_prio, m_pending;
    logic [2:0] m_col_prev;
    logic [7:0] m_count;
    int         n_vec = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    display_frame_scheduler #(
        .NUM_WR (2),
        .CNT_W  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_col       (wr_col),
        .wr_red       (wr_red),
        .wr_green     (wr_green),
        .wr_blue      (wr_blue),
        .clear_req    (clear_req),
        .commit_req   (commit_req),
        .commit_busy  (commit_busy),
        .commit_done  (commit_done),
        .commit_count (commit_count),
        .col_num      (col_num),
        .image_red    (image_red),
        .image_green  (image_green),
        .image_blue   (image_blue)
    );

    // Scoreboard consumer: every commit_done must match the oldest outstanding commit
    always @(negedge clk) begin
        if (rst === 1'b0 && commit_done === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_commit_done: got commit_done=1, required 0");
            end else begin
                mf = sb.pop_front();
                n_vec++;
                if (image_red !== mf.r || image_green !== mf.g || image_blue !== mf.b) begin
                    n_fail++;
                    $display("FAIL sb_frame: got R=%h G=%h B=%h, required R=%h G=%h B=%h",
                             image_red, image_green, image_blue, mf.r, mf.g, mf.b);
                end
                n_vec++;
                if (commit_count !== mf.cnt) begin
                    n_fail++;
                    $display("FAIL sb_count: got %0d, required %0d", commit_count, mf.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] exp_gnt();
        if (m_pending || clear_req) return 2'b00;
        case (wr_valid)
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return m_prio ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid   = 2'b00;
        wr_col     = '0;
        wr_red     = '0;
        wr_green   = '0;
        wr_blue    = '0;
        clear_req  = 1'b0;
        commit_req = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        col_num = 3'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_red = '0;
        m_green = '0;
        m_blue = '0;
        m_prio = 1'b0;
        m_pending = 1'b0;
        m_col_prev = 3'd0;
        m_count = 8'd0;
        sb.delete();
    endtask

    task automatic set_write(input int w, input logic [2:0] col,
                             input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        wr_valid[w] = 1'b1;
        wr_col[w]   = col;
        wr_red[w]   = r;
        wr_green[w] = g;
        wr_blue[w]  = b;
    endtask

    // Reference model of the coming clock edge, then advance one cycle
    task automatic model_edge();
        logic [1:0] g;
        logic       idx;
        frame_t     f;
        g = exp_gnt();
        if (!m_pending) begin
            if (clear_req) begin
                m_red = '0;
                m_green = '0;
                m_blue = '0;
            end else if (g != 2'b00) begin
                idx = g[1];
                m_red[wr_col[idx]]   = wr_red[idx];
                m_green[wr_col[idx]] = wr_green[idx];
                m_blue[wr_col[idx]]  = wr_blue[idx];
                m_prio = g[0];
            end
            if (commit_req) begin
                m_pending = 1'b1;
                f.r = m_red;
                f.g = m_green;
                f.b = m_blue;
                f.cnt = m_count + 8'd1;
                sb.push_back(f);
            end
        end else if (m_col_prev == 3'd7 && col_num == 3'd0) begin
            m_pending = 1'b0;
            m_count = m_count + 8'd1;
        end
        m_col_prev = col_num;
        tick();
    endtask

    // Drive col_num 1..7 then 0; the last edge is a frame boundary
    task automatic sweep_frame();
        for (int c = 1; c <= 8; c++) begin
            col_num = 3'(c % 8);
            model_edge();
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (image_red !== '0 || image_green !== '0 || image_blue !== '0) begin
            n_fail++;
            $display("FAIL reset_image: got R=%h G=%h B=%h, required all 0",
                     image_red, image_green, image_blue);
        end
        n_vec++;
        if (commit_busy !== 1'b0 || commit_done !== 1'b0 || commit_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_status: got busy=%b done=%b count=%0d, required 0 0 0",
                     commit_busy, commit_done, commit_count);
        end
        wr_valid = 2'b11;
        #1;
        n_vec++;
        if (wr_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_prio: got wr_ready=%b, required 01", wr_ready);
        end
        wr_valid = 2'b00;
    endtask

    task automatic test_single_commit();
        do_reset();
        set_write(0, 3'd3, 8'hF0, 8'h0F, 8'hAA);
        #1;
        n_vec++;
        if (wr_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL t1_grant: got wr_ready=%b, required 01", wr_ready);
        end
        model_edge();
        idle_inputs();
        commit_req = 1'b1;
        model_edge();
        commit_req = 1'b0;
        for (int c = 0; c < 9; c++) begin
            col_num = 3'(c % 8);
            #1;
            n_vec++;
            if (commit_busy !== 1'b1 || image_red !== '0 || image_blue !== '0) begin
                n_fail++;
                $display("FAIL t1_hold: step %0d got busy=%b R=%h B=%h, required 1 0 0",
                         c, commit_busy, image_red, image_blue);
            end
            model_edge();
        end
        n_vec++;
        if (image_red[3] !== 8'hF0 || image_green[3] !== 8'h0F || image_blue[3] !== 8'hAA) begin
            n_fail++;
            $display("FAIL t1_front: got %h %h %h, required f0 0f aa",
                     image_red[3], image_green[3], image_blue[3]);
        end
        n_vec++;
        if (commit_done !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_done_pulse: got %b, required 1", commit_done);
        end
        model_edge();
        n_vec++;
        if (commit_done !== 1'b0 || commit_busy !== 1'b0 || commit_count !== 8'd1) begin
            n_fail++;
            $display("FAIL t1_after: got done=%b busy=%b count=%0d, required 0 0 1",
                     commit_done, commit_busy, commit_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_write(0, 3'd0, 8'(8'h10 + k), 8'(8'h30 + k), 8'(8'h50 + k));
            set_write(1, 3'd1, 8'(8'h20 + k), 8'(8'h40 + k), 8'(8'h60 + k));
            #1;
            n_vec++;
            if (wr_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL t2_grant: beat %0d got wr_ready=%b, required alternate 01/10",
                         k, wr_ready);
            end
            model_edge();
        end
        idle_inputs();
        commit_req = 1'b1;
        model_edge();
        commit_req = 1'b0;
        sweep_frame();
        n_vec++;
        if (image_red[0] !== 8'h12 || image_red[1] !== 8'h23 || image_blue[1] !== 8'h63) begin
            n_fail++;
            $display("FAIL t2_last_data: got %h %h %h, required 12 23 63",
                     image_red[0], image_red[1], image_blue[1]);
        end
        model_edge();
    endtask

    task automatic test_commit_blocks_writes();
        do_reset();
        set_write(0, 3'd5, 8'h77, 8'h66, 8'h55);
        set_write(1, 3'd6, 8'h11, 8'h22, 8'h33);
        commit_req = 1'b1;
        #1;
        n_vec++;
        if (wr_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL t3_same_cycle_grant: got wr_ready=%b, required 01", wr_ready);
        end
        model_edge();
        for (int c = 1; c <= 8; c++) begin
            col_num = 3'(c % 8);
            commit_req = (c == 2);
            wr_red[0] = 8'(c);
            wr_red[1] = 8'(c);
            #1;
            n_vec++;
            if (wr_ready !== 2'b00 || commit_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL t3_blocked: step %0d got wr_ready=%b busy=%b, required 00 1",
                         c, wr_ready, commit_busy);
            end
            model_edge();
        end
        n_vec++;
        if (image_red[5] !== 8'h77 || image_red[6] !== 8'h00 || commit_count !== 8'd1) begin
            n_fail++;
            $display("FAIL t3_front: got col5=%h col6=%h count=%0d, required 77 00 1",
                     image_red[5], image_red[6], commit_count);
        end
        #1;
        n_vec++;
        if (wr_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL t3_resume: got wr_ready=%b, required 10", wr_ready);
        end
        model_edge();
        idle_inputs();
        sweep_frame();
        model_edge();
        n_vec++;
        if (commit_count !== 8'd1 || commit_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_single_commit: got count=%0d busy=%b, required 1 0",
                     commit_count, commit_busy);
        end
    endtask

    task automatic test_clear();
        do_reset();
        set_write(0, 3'd2, 8'hC3, 8'h3C, 8'h99);
        model_edge();
        idle_inputs();
        commit_req = 1'b1;
        model_edge();
        commit_req = 1'b0;
        sweep_frame();
        model_edge();
        n_vec++;
        if (image_red[2] !== 8'hC3 || image_blue[2] !== 8'h99) begin
            n_fail++;
            $display("FAIL t4_first_frame: got %h %h, required c3 99",
                     image_red[2], image_blue[2]);
        end
        clear_req = 1'b1;
        commit_req = 1'b1;
        set_write(0, 3'd4, 8'hFF, 8'hFF, 8'hFF);
        #1;
        n_vec++;
        if (wr_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL t4_clear_blocks: got wr_ready=%b, required 00", wr_ready);
        end
        model_edge();
        idle_inputs();
        sweep_frame();
        n_vec++;
        if (image_red !== '0 || image_green !== '0 || image_blue !== '0
            || commit_count !== 8'd2) begin
            n_fail++;
            $display("FAIL t4_cleared: got R=%h G=%h B=%h count=%0d, required 0 0 0 2",
                     image_red, image_green, image_blue, commit_count);
        end
        model_edge();
    endtask

    task automatic test_reset_pending();
        do_reset();
        set_write(0, 3'd4, 8'h81, 8'h42, 8'h24);
        model_edge();
        idle_inputs();
        commit_req = 1'b1;
        model_edge();
        commit_req = 1'b0;
        col_num = 3'd1;
        model_edge();
        col_num = 3'd2;
        model_edge();
        n_vec++;
        if (commit_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_pending: got busy=%b, required 1", commit_busy);
        end
        do_reset();
        n_vec++;
        if (commit_busy !== 1'b0 || image_red !== '0 || image_green !== '0) begin
            n_fail++;
            $display("FAIL t5_after_reset: got busy=%b R=%h G=%h, required 0 0 0",
                     commit_busy, image_red, image_green);
        end
        sweep_frame();
        model_edge();
        n_vec++;
        if (commit_count !== 8'd0 || image_red !== '0 || commit_done !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_no_commit: got count=%0d R=%h done=%b, required 0 0 0",
                     commit_count, image_red, commit_done);
        end
    endtask

    task automatic test_boundary_same_cycle();
        do_reset();
        set_write(1, 3'd6, 8'h5A, 8'hA5, 8'h3C);
        model_edge();
        idle_inputs();
        for (int c = 1; c <= 7; c++) begin
            col_num = 3'(c);
            model_edge();
        end
        col_num = 3'd0;
        commit_req = 1'b1;
        model_edge();
        commit_req = 1'b0;
        n_vec++;
        if (commit_busy !== 1'b1 || image_red[6] !== 8'h00) begin
            n_fail++;
            $display("FAIL t6_no_early: got busy=%b col6=%h, required 1 00",
                     commit_busy, image_red[6]);
        end
        sweep_frame();
        n_vec++;
        if (image_red[6] !== 8'h5A || image_green[6] !== 8'hA5 || image_blue[6] !== 8'h3C) begin
            n_fail++;
            $display("FAIL t6_next_boundary: got %h %h %h, required 5a a5 3c",
                     image_red[6], image_green[6], image_blue[6]);
        end
        model_edge();
    endtask

    initial begin
        test_reset();
        test_single_commit();
        test_back_to_back();
        test_commit_blocks_writes();
        test_clear();
        test_reset_pending();
        test_boundary_same_cycle();
        tick();
        tick();
        n_vec++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d commits outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
